// File: rtl/stone_drawer.sv
// rtl/stone_drawer.sv - per-frame item RAM scanner drawing 16x16 solid sprites; optional grabbed outline via STONE_DRAWER_OUTLINE_EN
module stone_drawer #(
  parameter int         SPRITE_SIZE    = 16,
  parameter int         RAM_LATENCY    = 2,
  parameter int         SCREEN_W       = 320,
  parameter int         SCREEN_H       = 240,
  parameter logic [2:0] COLOUR_STONE   = 3'b111,
  parameter logic [2:0] COLOUR_GOLD    = 3'b110,
  parameter logic [2:0] COLOUR_DIAMOND = 3'b011
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  quantity,
  input  logic [31:0] ram_q,
  output logic        draw_stone_flag,
  output logic [3:0]  draw_index,
  output logic [8:0]  vga_x,
  output logic [7:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        plot,
  output logic        done
);

  localparam int              OW        = $clog2(SPRITE_SIZE);
  localparam logic [OW-1:0]   OMAX      = OW'(SPRITE_SIZE - 1);
  localparam int              WW        = (RAM_LATENCY > 2) ? $clog2(RAM_LATENCY) : 1;
  localparam int              WAIT_LAST = (RAM_LATENCY > 2) ? RAM_LATENCY - 2 : 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_LATCH,
    S_PLOT,
    S_NEXT,
    S_FINISH
  } state_t;

  state_t         state;
  state_t         state_next;

  logic [3:0]     qty_r;
  logic [WW-1:0]  wait_cnt;
  logic [OW-1:0]  ox;
  logic [OW-1:0]  oy;
  logic [8:0]     x_r;
  logic [7:0]     y_r;
  logic [1:0]     type_r;
  logic           grab_r;

  logic [9:0]     sum_x;
  logic [8:0]     sum_y;
  logic           in_screen;
  logic           last_pixel;
  logic [2:0]     pix_colour;
  logic           unused_bits;

  // Wide sums so that sprites hanging off the right/bottom edge are clipped, not wrapped
  assign sum_x      = {1'b0, x_r} + 10'(ox);
  assign sum_y      = {1'b0, y_r} + 9'(oy);
  assign in_screen  = (sum_x < 10'(SCREEN_W)) && (sum_y < 9'(SCREEN_H));
  assign last_pixel = (ox == OMAX) && (oy == OMAX);

`ifdef STONE_DRAWER_OUTLINE_EN
  assign unused_bits = ^{ram_q[22:19], ram_q[10:4]};
`else
  assign unused_bits = ^{ram_q[22:19], ram_q[10:4], grab_r};
`endif

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic: walk entries, waiting out the RAM read latency before sampling each record
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start) state_next = S_ADDR;
      S_ADDR: begin
        if (draw_index >= qty_r)  state_next = S_FINISH;
        else if (RAM_LATENCY > 1) state_next = S_WAIT;
        else                      state_next = S_LATCH;
      end
      S_WAIT:   if (wait_cnt == WW'(WAIT_LAST)) state_next = S_LATCH;
      S_LATCH:  state_next = ram_q[1] ? S_PLOT : S_NEXT;
      S_PLOT:   if (last_pixel) state_next = S_NEXT;
      S_NEXT:   state_next = S_ADDR;
      S_FINISH: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Moore outputs: RAM ownership flag for the whole scan, done only in FINISH
  always_comb begin
    draw_stone_flag = 1'b0;
    done            = 1'b0;
    case (state)
      S_ADDR, S_WAIT, S_LATCH, S_PLOT, S_NEXT: draw_stone_flag = 1'b1;
      S_FINISH:                                done            = 1'b1;
      default: ;
    endcase
  end

  // Scan bookkeeping: latched quantity, RAM address, latency counter, record fields, sprite offsets
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      qty_r      <= '0;
      draw_index <= '0;
      wait_cnt   <= '0;
      ox         <= '0;
      oy         <= '0;
      x_r        <= '0;
      y_r        <= '0;
      type_r     <= '0;
      grab_r     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            qty_r      <= quantity;
            draw_index <= '0;
          end
        end
        S_ADDR: wait_cnt <= '0;
        S_WAIT: wait_cnt <= wait_cnt + WW'(1);
        S_LATCH: begin
          x_r    <= ram_q[31:23];
          y_r    <= ram_q[18:11];
          type_r <= ram_q[3:2];
          grab_r <= ram_q[0];
          ox     <= '0;
          oy     <= '0;
        end
        S_PLOT: begin
          if (ox == OMAX) begin
            ox <= '0;
            oy <= oy + OW'(1);
          end else begin
            ox <= ox + OW'(1);
          end
        end
        S_NEXT: draw_index <= draw_index + 4'd1;
        default: ;
      endcase
    end
  end

  // Pixel colour from item type, with the grabbed border override when enabled
  always_comb begin
    case (type_r)
      2'b00:   pix_colour = COLOUR_STONE;
      2'b01:   pix_colour = COLOUR_GOLD;
      default: pix_colour = COLOUR_DIAMOND;
    endcase
`ifdef STONE_DRAWER_OUTLINE_EN
    if (grab_r && ((ox == '0) || (ox == OMAX) || (oy == '0) || (oy == OMAX)))
      pix_colour = 3'b100;
`endif
  end

  // Registered pixel port: coordinates and colour travel with the plot strobe
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      plot       <= 1'b0;
    end else begin
      vga_x      <= sum_x[8:0];
      vga_y      <= sum_y[7:0];
      vga_colour <= pix_colour;
      plot       <= (state == S_PLOT) && in_screen;
    end
  end

endmodule

// File: doc/stone_drawer.md
Name: stone_drawer

Overview:
- Per-frame renderer for the item RAM: the read end of the item records the rope controller writes.
- On a frame start pulse it scans entries 0..quantity-1 through the shared RAM read port.
- For each visible entry it emits a 16x16 solid sprite, one pixel per clock, to the VGA adapter's plot interface.
- While scanning it holds draw_stone_flag so that the RAM address mux selects draw_index.

Parameters:
- SPRITE_SIZE, 16, sprite edge in pixels (power of two).
- RAM_LATENCY, 2, clocks from draw_index change to valid ram_q.
- SCREEN_W, 320, pixels with x >= SCREEN_W are not plotted.
- SCREEN_H, 240, pixels with y >= SCREEN_H are not plotted.
- COLOUR_STONE, 3'b111, colour for type 00.
- COLOUR_GOLD, 3'b110, colour for type 01.
- COLOUR_DIAMOND, 3'b011, colour for types 10 and 11.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  frame start pulse; sampled only in IDLE.
- quantity  in  4  number of RAM entries to scan; latched at start.
- ram_q  in  32  item RAM read data.
- draw_stone_flag  out  1  high while a scan owns the RAM address.
- draw_index  out  4  RAM read address.
- vga_x  out  9  pixel x.
- vga_y  out  8  pixel y.
- vga_colour  out  3  pixel colour.
- plot  out  1  pixel write strobe.
- done  out  1  one-cycle pulse at end of scan.

Behaviour:
- Record fields:
  - x = ram_q[31:23]
  - y = ram_q[18:11]
  - type = ram_q[3:2]
  - visible = ram_q[1]
  - grabbed = ram_q[0]
  - All other bits are ignored.
- Reset (asynchronous, any state): go to IDLE; all outputs 0; internal counters 0; latched quantity 0. A reset mid-scan drops draw_stone_flag and plot immediately and produces no done pulse.
- State machine:
  - IDLE: outputs low. On start=1, latch quantity, clear draw_index, go to ADDR.
  - ADDR: if draw_index >= latched quantity, go to FINISH; otherwise go to WAIT with draw_stone_flag=1.
  - WAIT: stay RAM_LATENCY-1 cycles, then go to LATCH.
  - LATCH: register x, y, type and grabbed from ram_q. If visible=0, go to NEXT; otherwise clear offset counters and go to PLOT.
  - PLOT: one pixel per cycle.
    - vga_x = x + ox, computed 10 bits wide; vga_y = y + oy, computed 9 bits wide.
    - plot=1 only when the wide sum < SCREEN_W (x) and < SCREEN_H (y). Clipped pixels still consume their cycle.
    - Order is row-major: ox increments first and wraps at SPRITE_SIZE-1, then oy increments.
    - After pixel (15,15), go to NEXT. Exactly 256 PLOT cycles per visible item.
  - NEXT: draw_index+1, go to ADDR.
  - FINISH: draw_stone_flag=0, done=1 for one cycle, go to IDLE.
- draw_stone_flag rises the cycle after start is accepted. It stays high from the first ADDR through NEXT of the last item and falls in FINISH.
- start while not in IDLE is ignored; it is not queued.
- quantity=0: start -> ADDR -> FINISH. done pulses on the 3rd clock after start, with no plot.
- Colour by type: 00 -> COLOUR_STONE, 01 -> COLOUR_GOLD, 10/11 -> COLOUR_DIAMOND.
- vga_x, vga_y and vga_colour are registered and aligned with plot. Their values are don't-care when plot=0.
- quantity changes during a scan are ignored.

Optional Feature:
- Macro: STONE_DRAWER_OUTLINE_EN.
- Defined: for an item with grabbed=1, pixels with ox or oy equal to 0 or SPRITE_SIZE-1 use colour 3'b100; interior pixels keep the type colour.
- Undefined: the grabbed bit is ignored and all 256 pixels use the type colour.

Test Plan:
- quantity=3; entries {x=40,y=50,type=01,vis}, {vis=0}, {x=100,y=60,type=00,vis}; start.
  - -> 512 plot pulses total.
  - First pixel (40,50) colour 110; last pixel (115,75) colour 111.
  - Entry 1 produces no plot.
  - done pulses once; draw_stone_flag is low after done.
- quantity=0, start -> done on the 3rd clock, no plot, draw_stone_flag high only during ADDR.
- One entry x=310, y=230 -> plot only for ox<10, oy<10: 100 pulses. PLOT still lasts 256 cycles.
- start re-pulsed mid-scan and quantity changed to 5 -> no effect; scan count unchanged; one done.
- Assert reset during PLOT of item 0 -> plot, draw_stone_flag and done are 0 asynchronously. After release, the next start scans from index 0.
- With STONE_DRAWER_OUTLINE_EN defined, entry x=0, y=0, type=10, grabbed=1 -> 60 border pixels colour 100, 196 interior pixels colour 011. Without the macro, all 256 pixels are 011.
